// File: rtl/dyn_adder_pipe_if.sv
// rtl/dyn_adder_pipe_if.sv - operand/result handshake bundle for dyn_adder_pipe
interface dyn_adder_pipe_if #(
  parameter int WIDTH = 16,
  parameter int LATW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             worst;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [LATW-1:0]  lat;

  modport master (
    output in_valid, a, b, cin, worst, out_ready,
    input  in_ready, out_valid, sum, cout, lat
  );

  modport slave (
    input  in_valid, a, b, cin, worst, out_ready,
    output in_ready, out_valid, sum, cout, lat
  );
endinterface

// File: rtl/dyn_adder_pipe.sv
// rtl/dyn_adder_pipe.sv - multi-cycle adder whose latency tracks the longest propagate run
module dyn_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int LATW  = 5
) (
  input logic             clk,
  input logic             rst_n,
  dyn_adder_pipe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   carry;
  logic [LATW-1:0]  cnt;
  logic [LATW-1:0]  k_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [LATW-1:0]  lat_r;

  logic [LATW-1:0]  k_in;
  logic [WIDTH:0]   carry_init;
  logic [WIDTH:0]   carry_nxt;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] g_r;

  // carry[i] is the carry into bit i; generate bits are exact from the start,
  // propagate bits start at 0 and are overwritten as the chain settles.
  assign carry_init = {bus.a & bus.b, bus.cin};
  assign p_r        = a_r ^ b_r;
  assign g_r        = a_r & b_r;

  always_comb begin
    int run;
    int lmax;
    run  = 0;
    lmax = 0;
    for (int i = 0; i < WIDTH; i++) begin
      run = (bus.a[i] ^ bus.b[i]) ? run + 1 : 0;
      if (run > lmax) lmax = run;
    end
    if (bus.worst) lmax = WIDTH;
    k_in = LATW'(1 + (lmax + SEG - 1) / SEG);
  end

  // Every bit looks one position down per step, all in parallel, SEG steps per clock.
  always_comb begin
    logic [WIDTH:0] c;
    c = carry;
    for (int s = 0; s < SEG; s++) begin
      c = {g_r | (p_r & c[WIDTH-1:0]), c[0]};
    end
    carry_nxt = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry       <= '0;
      cnt         <= '0;
      k_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      lat_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry      <= carry_init;
            k_r        <= k_in;
            cnt        <= LATW'(1);
            in_ready_r <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          carry <= carry_nxt;
          if (cnt == k_r) begin
            sum_r       <= p_r ^ carry_nxt[WIDTH-1:0];
            cout_r      <= carry_nxt[WIDTH];
            lat_r       <= k_r;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + LATW'(1);
          end
        end
        DONE: begin
          // in_ready stays low on this edge, so a same-edge in_valid is not taken
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.lat       = lat_r;
endmodule

// File: tb/tb_dyn_adder_pipe.sv
// tb/tb_dyn_adder_pipe.sv - scoreboard bench for dyn_adder_pipe with random operands and stalls
module tb_dyn_adder_pipe;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int LW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dyn_adder_pipe_if #(.WIDTH(W), .LATW(LW)) bus ();

  dyn_adder_pipe #(.WIDTH(W), .SEG(S), .LATW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic [LW-1:0] lat;
    int            t;
  } exp_t;

  exp_t exp_q[$];
  int   total     = 0;
  int   passed    = 0;
  int   cyc       = 0;
  int   stall_req = 0;
  bit   mon_busy  = 1'b0;
  bit   stress    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: exact sum from integer addition, latency from the longest run of differing bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic worst, input int t_neg);
    exp_t       e;
    logic [W:0] full;
    int         run, l, k;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    run  = 0;
    l    = 0;
    for (int i = 0; i < W; i++) begin
      run = (a[i] != b[i]) ? run + 1 : 0;
      if (run > l) l = run;
    end
    k      = worst ? 1 + (W + S - 1) / S : 1 + (l + S - 1) / S;
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.lat  = LW'(k);
    e.t    = t_neg + 1 + k;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic worst);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      // junk offered while busy must be ignored
      bus.in_valid = 1'($urandom);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.cin      = 1'($urandom);
      bus.worst    = 1'($urandom);
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", n);
      bus.in_valid = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.worst    = worst;
    exp_q.push_back(model(a, b, cin, worst, cyc));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || mon_busy) begin
      total++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  // Monitor: pops one expectation per presented result, rechecks it on every stalled cycle.
  initial begin
    exp_t cur;
    int   stall;
    bit   retired;
    stall         = 0;
    retired       = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (retired && rst_n) chk("valid_after_retire", bus.out_valid, 1'b0);
      retired = 1'b0;
      if (rst_n && bus.out_valid) begin
        if (!mon_busy) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: out_valid with nothing outstanding, sum=%0h", bus.sum);
            bus.out_ready = 1'b1;
          end else begin
            cur      = exp_q.pop_front();
            mon_busy = 1'b1;
            stall    = stall_req;
            stall_req = 0;
            chk("latency_cycles", cyc, cur.t);
          end
        end
        if (mon_busy) begin
          chk("sum", bus.sum, cur.sum);
          chk("cout", bus.cout, cur.cout);
          chk("lat", bus.lat, cur.lat);
          chk("in_ready_while_done", bus.in_ready, 1'b0);
          if (stall > 0) begin
            stall--;
            bus.out_ready = 1'b0;
          end else begin
            bus.out_ready = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
          if (bus.out_ready) begin
            mon_busy = 1'b0;
            retired  = 1'b1;
          end
        end
      end else begin
        bus.out_ready = 1'($urandom);
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    bus.worst    = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, '0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_lat", bus.lat, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    issue(16'h0003, 16'h0001, 1'b0, 1'b0);
    drain();
    stall_req = 3;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();
    issue(16'h1234, 16'h1234, 1'b0, 1'b1);
    issue(16'h8000, 16'h8000, 1'b1, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drain();

    // reset two edges into a worst-case operation: it must vanish
    issue(16'h00FF, 16'h0F0F, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_sum", bus.sum, '0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    issue(16'h7FFF, 16'h0001, 1'b1, 1'b0);
    drain();

    stress = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       rb = ra;
        2:       rb = W'($urandom_range(0, 15));
        default: rb = W'($urandom);
      endcase
      issue(ra, rb, 1'($urandom), $urandom_range(0, 3) == 0);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dyn_adder_pipe.md
DYN_ADDER_PIPE -- requirements
Module: dyn_adder_pipe

Interface
REQ-001 Parameter WIDTH, 16, operand and sum width in bits; legal range 4..64.
REQ-002 Parameter SEG, 4, carry positions resolved per clock; legal range 1..WIDTH.
REQ-003 Parameter LATW, 5, width of the latency report; the integrator sets it wide enough for 1+ceil(WIDTH/SEG).
REQ-004 One clock and one reset: reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operands valid.
REQ-008 in_ready  output  1  block accepts operands.
REQ-009 a, b  input  WIDTH  operands.
REQ-010 cin  input  1  carry-in.
REQ-011 worst  input  1  forces worst-case latency for this operation; sampled at acceptance.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  (a+b+cin) mod 2^WIDTH.
REQ-015 cout  output  1  carry out of bit WIDTH-1.
REQ-016 lat  output  LATW  number of cycles from acceptance to out_valid for this result.

Function
REQ-017 Acceptance occurs on a rising edge with in_valid=1 and in_ready=1; a, b, cin and worst are registered at that edge.
REQ-018 States: IDLE (in_ready=1, out_valid=0), CALC (in_ready=0, out_valid=0), DONE (in_ready=0, out_valid=1).
REQ-019 IDLE->CALC on acceptance; CALC->DONE when the settle count reaches K; DONE->IDLE on an edge with out_ready=1.
REQ-020 P[i]=a[i]^b[i]; L is the longest run of consecutive P=1 bits (0 if none).
REQ-021 K=1+ceil(L/SEG) when worst=0; K=1+ceil(WIDTH/SEG) when worst=1.
REQ-022 out_valid rises exactly K clock edges after the acceptance edge.
REQ-023 The carry chain advances by SEG bit positions per clock; sum and cout are computed from the chain state and equal exact a+b+cin when out_valid=1.
REQ-024 sum, cout and lat hold stable while out_valid=1 and out_ready=0.
REQ-025 lat equals K for the presented result.
REQ-026 in_valid while in_ready=0 is ignored, with no effect on state or outputs.
REQ-027 In DONE, out_ready=1 with in_valid=1 on the same edge does not accept; the next operation is accepted no earlier than the following edge in IDLE.
REQ-028 Wrap-around: overflow sets cout=1 and sum holds the low WIDTH bits.
REQ-029 A full propagate chain (L=WIDTH) without worst gives the same K as worst=1.

Reset
REQ-030 When rst_n=0, the block is in IDLE with in_ready=1, out_valid=0, sum=0, cout=0, lat=0, and the internal counter and carry state cleared, independent of clk.
REQ-031 Reset asserted in CALC or DONE discards the in-flight operation; no out_valid follows it.
REQ-032 After rst_n deasserts, the first acceptance can occur on the first rising edge.

Verification
REQ-033 WIDTH=16, SEG=4, a=16'hAAAA, b=16'h5555, cin=0 -> L=16, K=5, out_valid 5 edges after acceptance, sum=16'hFFFF, cout=0, lat=5.
REQ-034 a=16'h0003, b=16'h0001, cin=0, worst=0 -> L=1, K=2, sum=16'h0004, cout=0, lat=2.
REQ-035 a=16'hFFFF, b=16'h0001, cin=0 -> L=15, K=5, sum=16'h0000, cout=1; then out_ready held 0 for 3 cycles -> outputs stable, in_ready=0.
REQ-036 a=b=16'h1234, worst=1 -> L=0 but K=5, lat=5, sum=16'h2468.
REQ-037 rst_n pulsed low 2 cycles after acceptance -> out_valid stays 0, in_ready=1 immediately, the next operation completes correctly.
REQ-038 Random back-to-back operations with random out_ready stalls against a reference model, for (WIDTH,SEG)=(16,4),(32,1),(8,8) -> every sum, cout and lat matches; no lost or duplicated results.
